// File: rtl/axi4_lite_s_mem_pkg.sv
// ----------------------------------------------------------------------------
// axi4_lite_s_mem_pkg
//   Shared definitions for the AXI4-Lite memory responder:
//   - default bus widths (address, data, strobe, response)
//   - AXI response encodings (OKAY, SLVERR)
//   - read and write FSM state encodings
//   - helper that converts a service latency into a counter load value
// ----------------------------------------------------------------------------
package axi4_lite_s_mem_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_MASK_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int AXI_RESP_WIDTH = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_WAIT = 2'd1,
    WR_RESP = 2'd2
  } wr_state_t;

  // The WAIT state is occupied for 'latency' cycles, the last of which is
  // the one where the counter reads zero, hence the minus one.
  function automatic logic [7:0] latency_load(input int latency);
    return 8'(latency - 1);
  endfunction

endpackage

// File: rtl/axi4_lite_s_mem_if.sv
// ----------------------------------------------------------------------------
// axi4_lite_s_mem_if
//   AXI4-Lite bus bundle (ar, r, aw, w, b channels).
//   Modports:
//     master - drives ar/aw/w payload+valid and r/b ready
//     slave  - drives ar/aw/w ready and r/b payload+valid
// ----------------------------------------------------------------------------
interface axi4_lite_s_mem_if
  import axi4_lite_s_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int MASK_WIDTH = AXI_MASK_WIDTH,
  parameter int RESP_WIDTH = AXI_RESP_WIDTH
) ();

  logic                  pAXI4_ar_valid;
  logic [ADDR_WIDTH-1:0] pAXI4_ar_bits_addr;
  logic                  pAXI4_ar_ready;

  logic                  pAXI4_r_valid;
  logic [DATA_WIDTH-1:0] pAXI4_r_bits_data;
  logic [RESP_WIDTH-1:0] pAXI4_r_bits_resp;
  logic                  pAXI4_r_ready;

  logic                  pAXI4_aw_valid;
  logic [ADDR_WIDTH-1:0] pAXI4_aw_bits_addr;
  logic                  pAXI4_aw_ready;

  logic                  pAXI4_w_valid;
  logic [DATA_WIDTH-1:0] pAXI4_w_bits_data;
  logic [MASK_WIDTH-1:0] pAXI4_w_bits_strb;
  logic                  pAXI4_w_ready;

  logic                  pAXI4_b_valid;
  logic [RESP_WIDTH-1:0] pAXI4_b_bits_resp;
  logic                  pAXI4_b_ready;

  modport master (
    output pAXI4_ar_valid, pAXI4_ar_bits_addr,
    input  pAXI4_ar_ready,
    input  pAXI4_r_valid, pAXI4_r_bits_data, pAXI4_r_bits_resp,
    output pAXI4_r_ready,
    output pAXI4_aw_valid, pAXI4_aw_bits_addr,
    input  pAXI4_aw_ready,
    output pAXI4_w_valid, pAXI4_w_bits_data, pAXI4_w_bits_strb,
    input  pAXI4_w_ready,
    input  pAXI4_b_valid, pAXI4_b_bits_resp,
    output pAXI4_b_ready
  );

  modport slave (
    input  pAXI4_ar_valid, pAXI4_ar_bits_addr,
    output pAXI4_ar_ready,
    output pAXI4_r_valid, pAXI4_r_bits_data, pAXI4_r_bits_resp,
    input  pAXI4_r_ready,
    input  pAXI4_aw_valid, pAXI4_aw_bits_addr,
    output pAXI4_aw_ready,
    input  pAXI4_w_valid, pAXI4_w_bits_data, pAXI4_w_bits_strb,
    output pAXI4_w_ready,
    output pAXI4_b_valid, pAXI4_b_bits_resp,
    input  pAXI4_b_ready
  );

endinterface

// File: rtl/axi4_lite_s_delay.sv
// ----------------------------------------------------------------------------
// axi4_lite_s_delay
//   Loadable down-counter used to stretch the service latency of one channel.
//   Ports:
//     iClock   clock
//     iResetN  asynchronous active-low reset (counter -> 0)
//     i_load   load i_value into the counter this cycle
//     i_value  load value
//     o_done   counter is zero
//   The counter decrements on its own whenever it is non-zero and not being
//   loaded; it rests at zero between transactions.
// ----------------------------------------------------------------------------
module axi4_lite_s_delay #(
  parameter int WIDTH = 8
) (
  input  logic             iClock,
  input  logic             iResetN,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_done
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/axi4_lite_s_mem.sv
// ----------------------------------------------------------------------------
// axi4_lite_s_mem
//   AXI4-Lite responder bridging onto a simple synchronous memory with
//   separate read and write ports. Read and write channels run independent
//   FSMs, each with a LATENCY-cycle wait between address acceptance and the
//   memory access. Addresses outside [BASE_ADDR, BASE_ADDR+SIZE) answer
//   SLVERR without touching memory.
//   Ports:
//     iClock, iResetN     clock, asynchronous active-low reset
//     s_axi               AXI4-Lite bus (slave side)
//     oMemRdEn/Addr       read port; iMemRdData is combinational, same cycle
//     oMemWrEn/Addr/Data/Mask  write port, byte mask per data byte
//   LATENCY must lie in 1..255.
// ----------------------------------------------------------------------------
module axi4_lite_s_mem
  import axi4_lite_s_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int                    MASK_WIDTH = AXI_MASK_WIDTH,
  parameter int                    RESP_WIDTH = AXI_RESP_WIDTH,
  parameter int                    LATENCY    = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0] SIZE       = 32'h0800_0000
) (
  input  logic                  iClock,
  input  logic                  iResetN,
  axi4_lite_s_mem_if.slave      s_axi,
  output logic                  oMemRdEn,
  output logic [ADDR_WIDTH-1:0] oMemRdAddr,
  input  logic [DATA_WIDTH-1:0] iMemRdData,
  output logic                  oMemWrEn,
  output logic [ADDR_WIDTH-1:0] oMemWrAddr,
  output logic [DATA_WIDTH-1:0] oMemWrData,
  output logic [MASK_WIDTH-1:0] oMemWrMask
);

  // Clears the byte-offset bits so memory always sees word addresses.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(MASK_WIDTH - 1);
  localparam logic [7:0]            LOAD_VALUE = latency_load(LATENCY);
  localparam logic [RESP_WIDTH-1:0] R_OKAY     = RESP_WIDTH'(RESP_OKAY);
  localparam logic [RESP_WIDTH-1:0] R_SLVERR   = RESP_WIDTH'(RESP_SLVERR);

  // --------------------------------------------------------------------------
  // Read channel
  // --------------------------------------------------------------------------
  rd_state_t             r_rd_state, w_rd_next;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [RESP_WIDTH-1:0] r_rresp;
  logic [ADDR_WIDTH-1:0] w_rd_off;
  logic                  w_rd_hit, w_rd_done, w_rd_load, w_mem_rd_en;
  logic                  w_ar_ready, w_ar_hs;

  // Subtraction form avoids overflow of BASE_ADDR+SIZE at the top of memory.
  assign w_rd_off   = r_rd_addr - BASE_ADDR;
  assign w_rd_hit   = (r_rd_addr >= BASE_ADDR) && (w_rd_off < SIZE);
  assign w_ar_ready = (r_rd_state == RD_IDLE);
  assign w_ar_hs    = w_ar_ready && s_axi.pAXI4_ar_valid;

  always_comb begin
    w_rd_next   = r_rd_state;
    w_rd_load   = 1'b0;
    w_mem_rd_en = 1'b0;
    case (r_rd_state)
      RD_IDLE: begin
        if (w_ar_hs) begin
          w_rd_load = 1'b1;
          w_rd_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (w_rd_done) begin
          w_mem_rd_en = w_rd_hit;
          w_rd_next   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (s_axi.pAXI4_r_ready) begin
          w_rd_next = RD_IDLE;
        end
      end
      default: w_rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      r_rd_state <= RD_IDLE;
      r_rd_addr  <= '0;
      r_rdata    <= '0;
      r_rresp    <= '0;
    end else begin
      r_rd_state <= w_rd_next;
      if (w_rd_load) begin
        r_rd_addr <= s_axi.pAXI4_ar_bits_addr & ALIGN_MASK;
      end
      if ((r_rd_state == RD_WAIT) && w_rd_done) begin
        r_rdata <= w_rd_hit ? iMemRdData : '0;
        r_rresp <= w_rd_hit ? R_OKAY : R_SLVERR;
      end
    end
  end

  axi4_lite_s_delay #(.WIDTH(8)) u_rd_delay (
    .iClock  (iClock),
    .iResetN (iResetN),
    .i_load  (w_rd_load),
    .i_value (LOAD_VALUE),
    .o_done  (w_rd_done)
  );

  // --------------------------------------------------------------------------
  // Write channel
  // --------------------------------------------------------------------------
  wr_state_t             r_wr_state, w_wr_next;
  logic                  r_aw_got, r_w_got;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [MASK_WIDTH-1:0] r_wr_strb;
  logic [RESP_WIDTH-1:0] r_bresp;
  logic [ADDR_WIDTH-1:0] w_wr_off;
  logic                  w_wr_hit, w_wr_done, w_wr_load, w_mem_wr_en;
  logic                  w_aw_ready, w_w_ready, w_aw_hs, w_w_hs, w_b_hs;

  assign w_wr_off   = r_wr_addr - BASE_ADDR;
  assign w_wr_hit   = (r_wr_addr >= BASE_ADDR) && (w_wr_off < SIZE);
  assign w_aw_ready = (r_wr_state == WR_IDLE) && !r_aw_got;
  assign w_w_ready  = (r_wr_state == WR_IDLE) && !r_w_got;
  assign w_aw_hs    = w_aw_ready && s_axi.pAXI4_aw_valid;
  assign w_w_hs     = w_w_ready && s_axi.pAXI4_w_valid;
  assign w_b_hs     = (r_wr_state == WR_RESP) && s_axi.pAXI4_b_ready;

  always_comb begin
    w_wr_next   = r_wr_state;
    w_wr_load   = 1'b0;
    w_mem_wr_en = 1'b0;
    case (r_wr_state)
      WR_IDLE: begin
        // Address and data may arrive in either order or together.
        if ((r_aw_got || w_aw_hs) && (r_w_got || w_w_hs)) begin
          w_wr_load = 1'b1;
          w_wr_next = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (w_wr_done) begin
          // An all-zero strobe is a legal no-op write: OKAY, no access.
          w_mem_wr_en = w_wr_hit && (r_wr_strb != '0);
          w_wr_next   = WR_RESP;
        end
      end
      WR_RESP: begin
        if (s_axi.pAXI4_b_ready) begin
          w_wr_next = WR_IDLE;
        end
      end
      default: w_wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      r_wr_state <= WR_IDLE;
      r_aw_got   <= 1'b0;
      r_w_got    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_strb  <= '0;
      r_bresp    <= '0;
    end else begin
      r_wr_state <= w_wr_next;
      if (w_b_hs) begin
        r_aw_got <= 1'b0;
        r_w_got  <= 1'b0;
      end else begin
        if (w_aw_hs) begin
          r_aw_got  <= 1'b1;
          r_wr_addr <= s_axi.pAXI4_aw_bits_addr & ALIGN_MASK;
        end
        if (w_w_hs) begin
          r_w_got   <= 1'b1;
          r_wr_data <= s_axi.pAXI4_w_bits_data;
          r_wr_strb <= s_axi.pAXI4_w_bits_strb;
        end
      end
      if ((r_wr_state == WR_WAIT) && w_wr_done) begin
        r_bresp <= w_wr_hit ? R_OKAY : R_SLVERR;
      end
    end
  end

  axi4_lite_s_delay #(.WIDTH(8)) u_wr_delay (
    .iClock  (iClock),
    .iResetN (iResetN),
    .i_load  (w_wr_load),
    .i_value (LOAD_VALUE),
    .o_done  (w_wr_done)
  );

  // --------------------------------------------------------------------------
  // Outputs. Readies are masked by the reset input so they drop at once when
  // reset is applied, independent of the clock.
  // --------------------------------------------------------------------------
  assign s_axi.pAXI4_ar_ready    = w_ar_ready && iResetN;
  assign s_axi.pAXI4_r_valid     = (r_rd_state == RD_RESP);
  assign s_axi.pAXI4_r_bits_data = r_rdata;
  assign s_axi.pAXI4_r_bits_resp = r_rresp;

  assign s_axi.pAXI4_aw_ready    = w_aw_ready && iResetN;
  assign s_axi.pAXI4_w_ready     = w_w_ready && iResetN;
  assign s_axi.pAXI4_b_valid     = (r_wr_state == WR_RESP);
  assign s_axi.pAXI4_b_bits_resp = r_bresp;

  assign oMemRdEn   = w_mem_rd_en;
  assign oMemRdAddr = r_rd_addr;
  assign oMemWrEn   = w_mem_wr_en;
  assign oMemWrAddr = r_wr_addr;
  assign oMemWrData = r_wr_data;
  assign oMemWrMask = r_wr_strb;

endmodule
